// File: rtl/pwm_mux_pkg.sv
// Shared defaults and the per-channel duty register slot layout for the PWM mux.
package pwm_mux_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int CNT_W_DEF  = 8;
   localparam int SEL_W_DEF  = 2;

   // One channel's duty state at the default counter width: staged value, live value, staged flag.
   typedef struct packed {
      logic                 pend;
      logic [CNT_W_DEF-1:0] duty_pend;
      logic [CNT_W_DEF-1:0] duty_act;
   } duty_slot_t;

endpackage

// File: rtl/pwm_mux_if.sv
// Control, duty-write and output bundle of the PWM mux; master drives, slave is the mux.
interface pwm_mux_if import pwm_mux_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) ();

   logic              en;
   logic [CNT_W-1:0]  period;
   logic              wr_en;
   logic [SEL_W-1:0]  wr_ch;
   logic [CNT_W-1:0]  wr_duty;
   logic              wr_ready;
   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] pwm;
   logic              y;
   logic              period_end;

   modport master (
      output en, period, wr_en, wr_ch, wr_duty, sel,
      input  wr_ready, pwm, y, period_end
   );

   modport slave (
      input  en, period, wr_en, wr_ch, wr_duty, sel,
      output wr_ready, pwm, y, period_end
   );

endinterface

// File: rtl/pwm_ch.sv
// One PWM channel: double-buffered duty (staged until the cycle boundary) and the output flop.
module pwm_ch import pwm_mux_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cnt,
   input  logic             xfer,
   input  logic             wr_acc,
   input  logic [CNT_W-1:0] wr_duty,
   output logic             pend,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_act;
   logic [CNT_W-1:0] duty_pend;

   // A write is only accepted while pend is clear, so it can never collide with a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty_act  <= '0;
         duty_pend <= '0;
         pend      <= 1'b0;
         pwm       <= 1'b0;
      end else begin
         pwm <= en && (cnt < duty_act);
         if (wr_acc) begin
            duty_pend <= wr_duty;
            pend      <= 1'b1;
         end else if (xfer && pend) begin
            duty_act <= duty_pend;
            pend     <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pwm_mux_n.sv
// Shared PWM counter feeding NUM_CH channels, with boundary-synchronised period and output select.
module pwm_mux_n import pwm_mux_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input logic       clk,
   input logic       rst,
   pwm_mux_if.slave  bus
);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  period_q;
   logic [SEL_W-1:0]  sel_q;
   logic              wrap;
   logic              load;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] wr_acc;
   logic [NUM_CH-1:0] pwm_q;
   logic              wr_ready_c;
   logic              y_c;

   assign wrap = bus.en && (cnt == period_q);
   // Period, select and staged duties all switch together at the boundary or while idle.
   assign load = wrap || !bus.en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         period_q <= '0;
         sel_q    <= '0;
      end else begin
         if (!bus.en || wrap) cnt <= '0;
         else                 cnt <= cnt + CNT_W'(1);
         if (load) begin
            period_q <= bus.period;
            sel_q    <= bus.sel;
         end
      end
   end

   // Indices at or beyond NUM_CH match no channel: writes are always ready and dropped, y reads 0.
   always_comb begin
      wr_ready_c = 1'b1;
      y_c        = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.wr_ch == SEL_W'(i)) wr_ready_c = !pend[i];
         if (sel_q == SEL_W'(i))     y_c        = pwm_q[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr_acc[g] = bus.wr_en && (bus.wr_ch == SEL_W'(g)) && !pend[g];

      pwm_ch #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (bus.en),
         .cnt     (cnt),
         .xfer    (load),
         .wr_acc  (wr_acc[g]),
         .wr_duty (bus.wr_duty),
         .pend    (pend[g]),
         .pwm     (pwm_q[g])
      );
   end

   assign bus.period_end = wrap;
   assign bus.wr_ready   = wr_ready_c;
   assign bus.y          = y_c;
   assign bus.pwm        = pwm_q;

endmodule

// File: tb/tb_pwm_mux_n.sv
// Scenario bench for pwm_mux_n: a cycle model queues expected outputs that each scenario pops and checks.
module tb_pwm_mux_n;
   import pwm_mux_pkg::*;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int SW  = 3;

   typedef struct packed {
      logic [NCH-1:0] pwm;
      logic           y;
      logic           pe;
      logic           rdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_mux_if #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) bus ();

   pwm_mux_n #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   exp_t       sb_q[$];
   logic [CW-1:0] m_cnt, m_period_q;
   logic [SW-1:0] m_sel_q;
   logic [NCH-1:0] m_pwm;
   duty_slot_t m_slot[NCH];

   task automatic model_reset();
      m_cnt = '0; m_period_q = '0; m_sel_q = '0; m_pwm = '0;
      for (int i = 0; i < NCH; i++) m_slot[i] = '0;
   endtask

   // Drives one cycle's inputs, queues what the outputs must show this cycle, then advances the model.
   task automatic apply(input logic en, input logic [CW-1:0] period, input logic wr_en,
                        input logic [SW-1:0] wr_ch, input logic [CW-1:0] wr_duty, input logic [SW-1:0] sel);
      logic wrap, acc;
      logic [NCH-1:0] nxt;
      exp_t e;
      bus.en = en; bus.period = period; bus.wr_en = wr_en;
      bus.wr_ch = wr_ch; bus.wr_duty = wr_duty; bus.sel = sel;
      wrap  = en && (m_cnt == m_period_q);
      e.pwm = m_pwm;
      e.y   = (int'(m_sel_q) < NCH) ? m_pwm[int'(m_sel_q)] : 1'b0;
      e.pe  = wrap;
      e.rdy = (int'(wr_ch) < NCH) ? !m_slot[int'(wr_ch)].pend : 1'b1;
      acc   = wr_en && e.rdy && (int'(wr_ch) < NCH);
      sb_q.push_back(e);
      for (int i = 0; i < NCH; i++) nxt[i] = en && (m_cnt < m_slot[i].duty_act);
      if (wrap || !en) begin
         for (int i = 0; i < NCH; i++)
            if (m_slot[i].pend) begin
               m_slot[i].duty_act = m_slot[i].duty_pend;
               m_slot[i].pend     = 1'b0;
            end
         m_period_q = period;
         m_sel_q    = sel;
      end
      if (acc) begin
         m_slot[int'(wr_ch)].duty_pend = wr_duty;
         m_slot[int'(wr_ch)].pend      = 1'b1;
      end
      m_cnt = (!en || wrap) ? '0 : m_cnt + 1'b1;
      m_pwm = nxt;
      #2;
   endtask

   task automatic step(input logic en, input logic [CW-1:0] period, input logic wr_en,
                       input logic [SW-1:0] wr_ch, input logic [CW-1:0] wr_duty, input logic [SW-1:0] sel);
      @(posedge clk); #1;
      apply(en, period, wr_en, wr_ch, wr_duty, sel);
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b0;
      bus.en = 0; bus.period = '0; bus.wr_en = 0; bus.wr_ch = '0; bus.wr_duty = '0; bus.sel = '0;
      model_reset();
      #12;
      n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== 7'b0000_0_0_1) begin
         n_fail++; $display("FAIL reset_idle got pwm/y/pe/rdy=%b required 0000001", {bus.pwm, bus.y, bus.period_end, bus.wr_ready});
      end
      bus.en = 1'b1; #1;
      n_checks++;
      if ({bus.y, bus.period_end, bus.wr_ready} !== 3'b011) begin
         n_fail++; $display("FAIL reset_en got y/pe/rdy=%b required 011", {bus.y, bus.period_end, bus.wr_ready});
      end
      bus.en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      apply(1'b0, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
      e = sb_q.pop_front(); n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
         n_fail++; $display("FAIL reset_release got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      int hi = 0, pe = 0;
      for (int k = 0; k < 30; k++) begin
         step(1'b1, 8'd9, k == 0, 3'd0, 8'd3, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL basic k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (k >= 20 && bus.pwm[0]) hi++;
         if (k >= 20 && bus.period_end) pe++;
      end
      n_checks++; if (hi != 3) begin n_fail++; $display("FAIL basic_duty high=%0d required 3", hi); end
      n_checks++; if (pe != 1) begin n_fail++; $display("FAIL basic_period_end pulses=%0d required 1", pe); end
   endtask

   task automatic test_duty_edges();
      exp_t e;
      int h1 = 0, h2 = 0;
      for (int k = 0; k < 30; k++) begin
         step(1'b1, 8'd9, k < 2, (k == 0) ? 3'd1 : 3'd2, (k == 0) ? 8'd0 : 8'd12, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL duty_edges k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (k >= 15 && bus.pwm[1]) h1++;
         if (k >= 15 && bus.pwm[2]) h2++;
      end
      n_checks++; if (h1 != 0)  begin n_fail++; $display("FAIL duty0 high=%0d required 0", h1); end
      n_checks++; if (h2 != 15) begin n_fail++; $display("FAIL duty_over high=%0d required 15", h2); end
   endtask

   task automatic test_double_write();
      exp_t e;
      logic got = 1'b0;
      int h5 = 0, h7 = 0;
      for (int g = 0; g < 12 && m_cnt != 8'd1; g++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL dbl_sync got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
      end
      step(1'b1, 8'd9, 1'b1, 3'd0, 8'd5, 3'd0);
      e = sb_q.pop_front(); n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
         n_fail++; $display("FAIL dbl_first got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
      end
      n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_first_ready got %b required 1", bus.wr_ready); end
      for (int g = 0; g < 20 && !got; g++) begin
         step(1'b1, 8'd9, 1'b1, 3'd0, 8'd7, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL dbl_hold g=%0d got %b required %b", g, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (bus.period_end) begin
            n_checks++;
            if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL dbl_wrap_ready got %b required 0", bus.wr_ready); end
         end
         got = bus.wr_ready;
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL dbl_timeout wr_ready got 0 required 1 within 20 clocks"); end
      for (int j = 0; j < 20; j++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL dbl_apply j=%0d got %b required %b", j, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (j < 10 && bus.pwm[0])  h5++;
         if (j >= 10 && bus.pwm[0]) h7++;
      end
      n_checks++; if (h5 != 5) begin n_fail++; $display("FAIL dbl_first_value high=%0d required 5", h5); end
      n_checks++; if (h7 != 7) begin n_fail++; $display("FAIL dbl_second_value high=%0d required 7", h7); end
   endtask

   task automatic test_sel();
      exp_t e;
      logic seen_wrap = 1'b0, prev_y;
      int rises = 0;
      for (int g = 0; g < 12 && m_cnt != 8'd4; g++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL sel_sync got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
      end
      prev_y = bus.y;
      for (int j = 0; j < 14; j++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd2);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL sel j=%0d got %b required %b", j, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         n_checks++;
         if (bus.y !== bus.pwm[seen_wrap ? 2 : 0]) begin
            n_fail++; $display("FAIL sel_follow j=%0d y=%b required %b", j, bus.y, bus.pwm[seen_wrap ? 2 : 0]);
         end
         if (bus.y && !prev_y) rises++;
         prev_y = bus.y;
         if (bus.period_end) seen_wrap = 1'b1;
      end
      n_checks++; if (rises != 1) begin n_fail++; $display("FAIL sel_glitch rises=%0d required 1", rises); end
   endtask

   task automatic test_period0();
      exp_t e;
      int pe = 0, h3 = 0;
      for (int k = 0; k < 25; k++) begin
         step(1'b1, 8'd0, k == 0, 3'd3, 8'd1, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL period0 k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (k >= 13 && bus.period_end) pe++;
         if (k >= 13 && bus.pwm[3])     h3++;
      end
      n_checks++; if (pe != 12) begin n_fail++; $display("FAIL period0_pe count=%0d required 12", pe); end
      n_checks++; if (h3 != 12) begin n_fail++; $display("FAIL period0_pwm3 count=%0d required 12", h3); end
   endtask

   task automatic test_reset_pending();
      exp_t e;
      int h1 = 0;
      for (int g = 0; g < 15 && m_cnt != 8'd5; g++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL rstp_sync got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
      end
      step(1'b1, 8'd9, 1'b1, 3'd1, 8'd8, 3'd0);
      e = sb_q.pop_front(); n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
         n_fail++; $display("FAIL rstp_write got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
      end
      step(1'b1, 8'd9, 1'b0, 3'd1, 8'd0, 3'd0);
      e = sb_q.pop_front(); n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
         n_fail++; $display("FAIL rstp_pending got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
      end
      rst = 1'b0; #1;
      model_reset();
      n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== 7'b0000_0_1_1) begin
         n_fail++; $display("FAIL rstp_async got pwm/y/pe/rdy=%b required 0000011", {bus.pwm, bus.y, bus.period_end, bus.wr_ready});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({bus.pwm, bus.y} !== 5'b0) begin n_fail++; $display("FAIL rstp_held got pwm/y=%b required 00000", {bus.pwm, bus.y}); end
      rst = 1'b1;
      apply(1'b1, 8'd9, 1'b0, 3'd1, 8'd0, 3'd0);
      e = sb_q.pop_front(); n_checks++;
      if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
         n_fail++; $display("FAIL rstp_release got %b required %b", {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
      end
      for (int k = 0; k < 24; k++) begin
         step(1'b1, 8'd9, 1'b0, 3'd0, 8'd0, 3'd0);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL rstp_run k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (bus.pwm[1]) h1++;
      end
      n_checks++; if (h1 != 0) begin n_fail++; $display("FAIL rstp_discard pwm1 high=%0d required 0", h1); end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      for (int k = 0; k < 25; k++) begin
         step(1'b1, 8'd9, (k == 0) || (k == 14), (k == 0) ? 3'd2 : 3'd6, (k == 0) ? 8'd12 : 8'd3, 3'd5);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL oor k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (k >= 13) begin
            n_checks++;
            if ({bus.pwm, bus.y} !== 5'b0100_0) begin
               n_fail++; $display("FAIL oor_out k=%0d got pwm/y=%b required 01000", k, {bus.pwm, bus.y});
            end
         end
         if (k == 14) begin
            n_checks++;
            if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready got %b required 1", bus.wr_ready); end
         end
      end
   endtask

   task automatic test_enable();
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         step(k >= 2, 8'd9, 1'b0, 3'd0, 8'd0, 3'd2);
         e = sb_q.pop_front(); n_checks++;
         if ({bus.pwm, bus.y, bus.period_end, bus.wr_ready} !== e) begin
            n_fail++; $display("FAIL enable k=%0d got %b required %b", k, {bus.pwm, bus.y, bus.period_end, bus.wr_ready}, e);
         end
         if (k == 1) begin
            n_checks++;
            if ({bus.pwm, bus.y} !== 5'b0) begin n_fail++; $display("FAIL en_low got pwm/y=%b required 00000", {bus.pwm, bus.y}); end
         end
         if (k == 3) begin
            n_checks++;
            if ({bus.pwm, bus.y} !== 5'b0100_1) begin n_fail++; $display("FAIL en_restart got pwm/y=%b required 01001", {bus.pwm, bus.y}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_edges();
      test_double_write();
      test_sel();
      test_period0();
      test_reset_pending();
      test_out_of_range();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
